// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: decodes the header destination, paces header,
// payload and parity writes into the output FIFOs, and stalls the source.
//  state | meaning
//  DA    | waiting for a header; latches dest
//  LFD   | header byte written through the register block
//  LD    | payload streaming into the destination FIFO
//  WTE   | destination FIFO still holds an older packet
//  FFS   | destination FIFO full, writes paused
//  LAF   | write the byte held back while the FIFO was full
//  LP    | parity byte written
//  CPE   | parity compare in the register block
module router_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [1:0] dest,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        WTE = 3'd3,
        FFS = 3'd4,
        LAF = 3'd5,
        LP  = 3'd6,
        CPE = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] dest_d;
    logic [3:0] empty_vec;
    logic [3:0] soft_vec;
    logic       hdr_ok;

    // Address 3 maps to a constant 0 so invalid headers can never index past the FIFOs.
    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_ok    = pkt_valid && (data_in != 2'b11);

    always_comb begin
        state_d = state_q;
        dest_d  = dest;
        case (state_q)
            DA: begin
                if (hdr_ok) begin
                    dest_d  = data_in;
                    state_d = empty_vec[data_in] ? LFD : WTE;
                end
            end
            WTE:     state_d = empty_vec[dest] ? LFD : WTE;
            LFD:     state_d = LD;
            LD: begin
                if (fifo_full)       state_d = FFS;
                else if (!pkt_valid) state_d = LP;
                else                 state_d = LD;
            end
            FFS:     state_d = fifo_full ? FFS : LAF;
            LAF: begin
                if (parity_done)        state_d = DA;
                else if (low_pkt_valid) state_d = LP;
                else                    state_d = LD;
            end
            LP:      state_d = CPE;
            CPE:     state_d = fifo_full ? FFS : DA;
            default: state_d = DA;
        endcase
        // A read-timeout on the selected destination abandons the packet.
        if ((state_q != DA) && soft_vec[dest]) state_d = DA;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= DA;
            dest          <= 2'b00;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            dest          <= dest_d;
            detect_add    <= (state_d == DA);
            lfd_state     <= (state_d == LFD);
            ld_state      <= (state_d == LD);
            laf_state     <= (state_d == LAF);
            full_state    <= (state_d == FFS);
            rst_int_reg   <= (state_d == CPE);
            write_enb_reg <= (state_d == LD) || (state_d == LP) || (state_d == LAF);
            busy          <= !((state_d == DA) || (state_d == LD));
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks packet flows and checks the Moore
// output vector and latched dest after every clock edge.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [1:0] dest;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    int checks = 0;
    int errors = 0;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0010;
    localparam logic [7:0] O_WTE = 8'b0000_0001;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LAF = 8'b0001_0011;
    localparam logic [7:0] O_LP  = 8'b0000_0011;
    localparam logic [7:0] O_CPE = 8'b0000_0101;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .dest(dest), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick_chk(input string tag, input logic [7:0] exp_o);
        @(posedge clock);
        #1;
        check_eq(tag, {detect_add, lfd_state, ld_state, laf_state, full_state,
                       rst_int_reg, write_enb_reg, busy}, exp_o);
    endtask

    task automatic chk_dest(input string tag, input logic [1:0] exp_d);
        check_eq(tag, {6'b0, dest}, {6'b0, exp_d});
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        tick_chk("rst_state", O_DA);
        chk_dest("rst_dest", 2'd0);
        reset = 1'b0;

        // Normal packet to dest 1, 3 payload bytes
        pkt_valid = 1'b1; data_in = 2'b01;
        tick_chk("n_lfd", O_LFD);
        chk_dest("n_dest", 2'd1);
        data_in = 2'b10;
        tick_chk("n_ld1", O_LD);
        tick_chk("n_ld2", O_LD);
        tick_chk("n_ld3", O_LD);
        pkt_valid = 1'b0;
        tick_chk("n_lp", O_LP);
        tick_chk("n_cpe", O_CPE);
        tick_chk("n_da", O_DA);
        tick_chk("n_idle", O_DA);

        // Destination 2 still occupied
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'b10;
        tick_chk("w_wte1", O_WTE);
        chk_dest("w_dest", 2'd2);
        for (int i = 0; i < 4; i++) tick_chk("w_wte_hold", O_WTE);
        fifo_empty_2 = 1'b1;
        tick_chk("w_lfd", O_LFD);
        tick_chk("w_ld", O_LD);

        // FIFO full mid-payload
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) tick_chk("f_ffs", O_FFS);
        fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        tick_chk("f_laf", O_LAF);
        tick_chk("f_lp", O_LP);
        low_pkt_valid = 1'b0;
        tick_chk("f_cpe", O_CPE);
        tick_chk("f_da", O_DA);

        // Invalid address 3 is dropped
        pkt_valid = 1'b1; data_in = 2'b11;
        for (int i = 0; i < 3; i++) tick_chk("inv_da", O_DA);
        chk_dest("inv_dest", 2'd2);

        // Soft reset: only the selected destination aborts
        data_in = 2'b00;
        tick_chk("s_lfd", O_LFD);
        chk_dest("s_dest", 2'd0);
        tick_chk("s_ld", O_LD);
        soft_reset_1 = 1'b1;
        tick_chk("s_other", O_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick_chk("s_abort", O_DA);
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;
        tick_chk("s_idle", O_DA);

        // fifo_full beats !pkt_valid; LAF->LD; CPE->FFS; LAF->DA on parity_done
        pkt_valid = 1'b1; data_in = 2'b01;
        tick_chk("p_lfd", O_LFD);
        chk_dest("p_dest", 2'd1);
        tick_chk("p_ld", O_LD);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        tick_chk("p_full_wins", O_FFS);
        fifo_full = 1'b0;
        tick_chk("p_laf", O_LAF);
        tick_chk("p_laf_ld", O_LD);
        tick_chk("p_lp", O_LP);
        fifo_full = 1'b1;
        tick_chk("p_cpe", O_CPE);
        tick_chk("p_cpe_ffs", O_FFS);
        fifo_full = 1'b0; parity_done = 1'b1;
        tick_chk("p_laf2", O_LAF);
        tick_chk("p_laf_da", O_DA);
        parity_done = 1'b0;

        // Soft reset on dest 2 while waiting in WTE
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'b10;
        tick_chk("sw_wte", O_WTE);
        pkt_valid = 1'b0; soft_reset_2 = 1'b1;
        tick_chk("sw_abort", O_DA);
        chk_dest("sw_dest", 2'd2);
        soft_reset_2 = 1'b0; fifo_empty_2 = 1'b1;

        // Synchronous reset mid-LD
        pkt_valid = 1'b1; data_in = 2'b10;
        tick_chk("r_lfd", O_LFD);
        tick_chk("r_ld", O_LD);
        reset = 1'b1;
        tick_chk("r_da1", O_DA);
        chk_dest("r_dest", 2'd0);
        tick_chk("r_da2", O_DA);
        reset = 1'b0; pkt_valid = 1'b0;
        tick_chk("r_idle", O_DA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
# router_fsm

Control state machine for the 1x3 router. It sequences the input register block and the write path into the three output FIFOs. It decodes the destination from the header byte and paces header, payload and parity loading. It stalls the source via `busy` while a destination FIFO is occupied or full, and aborts a packet when the destination's soft reset fires.

## Interface
Parameters: none (3 destinations fixed; address 2'b11 invalid).

- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; returns FSM to DECODE_ADDRESS
- `pkt_valid`  in  1  source packet strobe; high for header+payload, low on parity byte
- `data_in`  in  2  header address bits [1:0] (sampled in DECODE_ADDRESS only)
- `fifo_full`  in  1  full flag of the currently selected destination FIFO
- `fifo_empty_0/1/2`  in  1 each  empty flags of the destination FIFOs
- `soft_reset_0/1/2`  in  1 each  per-destination packet abort (read-timeout from output side)
- `parity_done`  in  1  register block has captured the parity byte
- `low_pkt_valid`  in  1  register block has seen pkt_valid drop
- `dest`  out  2  latched destination address
- `detect_add`  out  1  state == DECODE_ADDRESS
- `lfd_state`  out  1  state == LOAD_FIRST_DATA
- `ld_state`  out  1  state == LOAD_DATA
- `laf_state`  out  1  state == LOAD_AFTER_FULL
- `full_state`  out  1  state == FIFO_FULL_STATE
- `rst_int_reg`  out  1  state == CHECK_PARITY_ERROR
- `write_enb_reg`  out  1  FIFO write enable: LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL
- `busy`  out  1  source stall; low only in DECODE_ADDRESS and LOAD_DATA

## Operation
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), WAIT_TILL_EMPTY (WTE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE). 3-bit binary encoding, single registered state; all outputs are pure Moore decodes of state.
- `dest` is loaded with `data_in` in DA when `pkt_valid`=1 and `data_in`!=2'b11; it holds otherwise.
- Transitions:
  - DA: pkt_valid & addr!=3 & fifo_empty[addr] -> LFD; pkt_valid & addr!=3 & !fifo_empty[addr] -> WTE; otherwise stay. addr=3 headers are dropped.
  - WTE: fifo_empty[dest] -> LFD; else stay.
  - LFD: -> LD unconditionally.
  - LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay.
  - FFS: !fifo_full -> LAF; else stay.
  - LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
  - LP: -> CPE.
  - CPE: fifo_full -> FFS; else -> DA.
- Soft reset: in any state except DA, soft_reset_[dest]=1 forces next state DA. This overrides all other transitions. Soft resets of non-selected destinations are ignored.
- Priority: reset > soft_reset_[dest] > normal transition.

## Timing
- Reset values: state=DA, dest=2'b00, detect_add=1, all other outputs 0 (busy=0, write_enb_reg=0).
- Header accepted in DA with empty FIFO: LFD next cycle (busy=1 for exactly 1 cycle), then LD.
- Header to first payload write: 2 cycles (LFD writes the header via the register block; write_enb_reg is asserted from LD).
- Parity: pkt_valid low in LD -> LP (1 cycle) -> CPE (1 cycle) -> DA. Minimum packet (header+1 payload+parity) occupies DA→LFD→LD→LP→CPE→DA.
- FIFO full in LD: FFS the next cycle, busy=1, write_enb_reg=0. Stays in FFS for as long as fifo_full=1. After fifo_full drops, LAF lasts 1 cycle, then LD/LP/DA as above.
- Simultaneous fifo_full and !pkt_valid in LD: fifo_full wins (-> FFS).
- Soft reset mid-packet: DA on the next edge; `dest` keeps the old value until a new valid header arrives.

## Test plan
- Reset: assert reset 2 cycles mid-LD -> state DA, detect_add=1, busy=0, dest=0 on the first edge.
- Normal packet to dest 1: fifo_empty_1=1, header 8'h05, 3 payload bytes, then parity -> states DA,LFD,LD,LD,LD,LP,CPE,DA. dest=1, busy high only in LFD/LP/CPE, write_enb_reg high in LD×3 and LP.
- Busy destination: header addr 2 with fifo_empty_2=0 for 5 cycles -> WTE held for 5 cycles with busy=1. fifo_empty_2 rises -> LFD next cycle.
- FIFO full mid-payload: fifo_full=1 in LD for 4 cycles -> FFS for 4 cycles with write_enb_reg=0, then LAF for 1 cycle. With low_pkt_valid=1 and parity_done=0 -> LP, then CPE.
- Invalid address: pkt_valid=1, data_in=2'b11 for 3 cycles -> remains in DA, dest unchanged, busy=0.
- Soft reset: in LD to dest 0, pulse soft_reset_1 -> no effect. Then pulse soft_reset_0 -> DA next cycle, detect_add=1.
